// File: rtl/wb_master.sv
// rtl/wb_master.sv - Wishbone B4 classic single-transfer initiator with bus timeout
module wb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_sel,
    output logic                rsp_valid,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                CYC,
    output logic                STB,
    output logic                WE,
    output logic [ADDR_W-1:0]   ADR,
    output logic [DATA_W-1:0]   DAT_O,
    output logic [DATA_W/8-1:0] SEL,
    input  logic [DATA_W-1:0]   DAT_I,
    input  logic                ACK,
    input  logic                ERR
);

    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [31:0]      TIMEOUT_L = 32'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  adr_q, adr_d;
    logic [DATA_W-1:0]  dat_o_q, dat_o_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        cnt_ext;
    logic               timeout_hit;

    // Timeout fires on the edge that closes the TIMEOUT-th bus cycle.
    always_comb begin
        cnt_ext     = 32'(cnt_q);
        timeout_hit = (TIMEOUT != 0) && ((cnt_ext + 32'd1) == TIMEOUT_L);
    end

    // Next-state and registered-output decode for the single-transfer FSM.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_o_d     = dat_o_q;
        sel_d       = sel_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    adr_d   = req_addr;
                    dat_o_d = req_wdata;
                    sel_d   = req_sel;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                if (ERR) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end else if (ACK) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    if (!we_q) begin
                        rsp_rdata_d = DAT_I;
                    end
                    state_d     = RESP;
                end else if (timeout_hit) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                // Spending a cycle here keeps CYC low long enough to swallow a late ACK.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops the bus immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_o_q     <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_o_q     <= dat_o_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            cnt_q       <= cnt_d;
        end
    end

    // Output mapping; req_ready is the only state-decoded output.
    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = rsp_valid_q;
        rsp_err   = rsp_err_q;
        rsp_rdata = rsp_rdata_q;
        CYC       = cyc_q;
        STB       = stb_q;
        WE        = we_q;
        ADR       = adr_q;
        DAT_O     = dat_o_q;
        SEL       = sel_q;
    end

endmodule

// File: tb/tb_wb_master.sv
// tb/tb_wb_master.sv - directed self-checking bench for wb_master
module tb_wb_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_sel;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_o, dat_i;
    logic [3:0]  sel;
    logic        ack = 1'b0;
    logic        err = 1'b0;

    logic        rv8, rr8, rsv8, rse8, cyc8, stb8, we8;
    logic [31:0] rsd8, adr8, dato8;
    logic [3:0]  sel8;
    logic        rv0, rr0, rsv0, rse0, cyc0, stb0, we0;
    logic [31:0] rsd0, adr0, dato0;
    logic [3:0]  sel0;
    logic        zero_b = 1'b0;
    logic [31:0] zero_w = 32'd0;

    int total = 0;
    int bad   = 0;

    wb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) u_dut (
        .clk(clk), .rst(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .CYC(cyc), .STB(stb), .WE(we), .ADR(adr), .DAT_O(dat_o), .SEL(sel),
        .DAT_I(dat_i), .ACK(ack), .ERR(err)
    );

    wb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) u_to8 (
        .clk(clk), .rst(rst_n),
        .req_valid(rv8), .req_ready(rr8), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
        .rsp_valid(rsv8), .rsp_err(rse8), .rsp_rdata(rsd8),
        .CYC(cyc8), .STB(stb8), .WE(we8), .ADR(adr8), .DAT_O(dato8), .SEL(sel8),
        .DAT_I(zero_w), .ACK(zero_b), .ERR(zero_b)
    );

    wb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) u_to0 (
        .clk(clk), .rst(rst_n),
        .req_valid(rv0), .req_ready(rr0), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
        .rsp_valid(rsv0), .rsp_err(rse0), .rsp_rdata(rsd0),
        .CYC(cyc0), .STB(stb0), .WE(we0), .ADR(adr0), .DAT_O(dato0), .SEL(sel0),
        .DAT_I(zero_w), .ACK(zero_b), .ERR(zero_b)
    );

    // Registered-ACK RAM responder: acks after ack_delay strobe cycles and keeps
    // acking while STB stays high, so it produces the classic one-cycle-late ACK.
    int          ack_delay = 1;
    bit          err_mode  = 1'b0;
    int          wcnt      = 0;
    logic [31:0] mem [0:255];

    assign dat_i = mem[adr[9:2]];

    always @(posedge clk) begin
        if (!rst_n || !(cyc && stb)) begin
            wcnt <= 0;
            ack  <= 1'b0;
            err  <= 1'b0;
        end else begin
            wcnt <= wcnt + 1;
            if (wcnt + 1 >= ack_delay) begin
                ack <= 1'b1;
                err <= err_mode;
                if (we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (sel[b]) mem[adr[9:2]][8*b +: 8] <= dat_o[8*b +: 8];
                    end
                end
            end else begin
                ack <= 1'b0;
                err <= 1'b0;
            end
        end
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input string tag);
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_before_accept: req_ready=%b rsp_valid=%b required 1/0",
                     tag, req_ready, rsp_valid);
        end
        req_we = w; req_addr = a; req_wdata = d; req_sel = s;
        req_valid = 1'b1;
        @(posedge clk);
    endtask

    task automatic wait_rsp(input int maxc, output int k, output int hi_cyc, output int hi_stb,
                            output bit adr_moved, output logic e, output logic [31:0] rd);
        logic [31:0] first_adr;
        bit seen;
        k = 0; hi_cyc = 0; hi_stb = 0; adr_moved = 0; seen = 0; first_adr = '0;
        while (k < maxc) begin
            @(negedge clk);
            k++;
            if (k == 1) req_valid = 1'b0;
            if (cyc) hi_cyc++;
            if (stb) begin
                hi_stb++;
                if (!seen) begin first_adr = adr; seen = 1; end
                else if (adr !== first_adr) adr_moved = 1;
            end
            if (rsp_valid) break;
        end
        if (!rsp_valid) k = maxc + 1;
        e  = rsp_err;
        rd = rsp_rdata;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; rv8 = 1'b0; rv0 = 1'b0;
        req_we = 1'b0; req_addr = '0; req_wdata = '0; req_sel = '0;
        #12;
        total++;
        if ({cyc, stb, we, rsp_valid, rsp_err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: cyc/stb/we/rv/re=%b required 00000", {cyc, stb, we, rsp_valid, rsp_err});
        end
        total++;
        if ({adr, dat_o, sel, rsp_rdata} !== 100'b0) begin
            bad++;
            $display("FAIL reset_data: adr=%h dat_o=%h sel=%h rdata=%h required all zero", adr, dat_o, sel, rsp_rdata);
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
        end
        total++;
        if ({cyc8, stb8, we8, adr8, dato8, sel8, rsv8, rse8, rsd8, rr8} !== {104'b0, 1'b1} ||
            {cyc0, stb0, we0, adr0, dato0, sel0, rsv0, rse0, rsd0, rr0} !== {104'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_other_inst: to8 cyc=%b rdy=%b to0 cyc=%b rdy=%b required 0/1", cyc8, rr8, cyc0, rr0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read;
        int k, hc, hs; bit mv; logic e; logic [31:0] rd;
        ack_delay = 1;
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr");
        wait_rsp(20, k, hc, hs, mv, e, rd);
        total++;
        if (k != 3 || hc != 2 || e !== 1'b0) begin
            bad++;
            $display("FAIL write: rsp_cycle=%0d cyc_hi=%0d err=%b required 3/2/0", k, hc, e);
        end
        issue(1'b0, 32'h10, 32'h0, 4'hF, "rd");
        wait_rsp(20, k, hc, hs, mv, e, rd);
        total++;
        if (k != 3 || hc != 2 || e !== 1'b0) begin
            bad++;
            $display("FAIL read_timing: rsp_cycle=%0d cyc_hi=%0d err=%b required 3/2/0", k, hc, e);
        end
        total++;
        if (rd !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL read_data: rdata=%h required deadbeef", rd);
        end
    endtask

    task automatic test_back_to_back;
        int acc, pulses, low_run, gap_min; bit drop, seen_hi;
        acc = 0; pulses = 0; low_run = 0; gap_min = 99; drop = 0; seen_hi = 0;
        ack_delay = 1;
        req_we = 1'b0; req_addr = 32'h14; req_sel = 4'hF;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (drop) begin req_valid = 1'b0; drop = 0; end
            if (rsp_valid) pulses++;
            if (cyc) begin
                if (seen_hi && low_run > 0 && low_run < gap_min) gap_min = low_run;
                low_run = 0; seen_hi = 1;
            end else if (seen_hi) begin
                low_run++;
            end
            if (n == 0) req_valid = 1'b1;
            if (req_valid && req_ready) begin
                acc++;
                if (acc == 2) drop = 1;
            end
        end
        total++;
        if (acc != 2 || pulses != 2) begin
            bad++;
            $display("FAIL b2b_count: accepts=%0d pulses=%0d required 2/2", acc, pulses);
        end
        total++;
        if (gap_min < 2 || gap_min == 99) begin
            bad++;
            $display("FAIL b2b_gap: min_cyc_low=%0d required >=2", gap_min);
        end
        total++;
        if (rsp_rdata !== 32'h0BADF00D) begin
            bad++;
            $display("FAIL b2b_data: rdata=%h required 0badf00d", rsp_rdata);
        end
    endtask

    task automatic test_wait_state;
        int k, hc, hs; bit mv; logic e; logic [31:0] rd;
        ack_delay = 5;
        issue(1'b0, 32'h40, 32'h0, 4'hF, "ws");
        wait_rsp(40, k, hc, hs, mv, e, rd);
        total++;
        if (hs != 6 || mv || k != 7) begin
            bad++;
            $display("FAIL wait_stb: stb_hi=%0d adr_moved=%0d rsp_cycle=%0d required 6/0/7", hs, mv, k);
        end
        total++;
        if (rd !== 32'h12345678 || e !== 1'b0) begin
            bad++;
            $display("FAIL wait_data: rdata=%h err=%b required 12345678/0", rd, e);
        end
        ack_delay = 1;
    endtask

    task automatic test_err_ack;
        int k, hc, hs; bit mv; logic e; logic [31:0] rd;
        ack_delay = 1;
        issue(1'b0, 32'h20, 32'h0, 4'hF, "pre");
        wait_rsp(20, k, hc, hs, mv, e, rd);
        total++;
        if (rd !== 32'hA5A5A5A5 || e !== 1'b0) begin
            bad++;
            $display("FAIL err_pre: rdata=%h err=%b required a5a5a5a5/0", rd, e);
        end
        err_mode = 1'b1;
        issue(1'b0, 32'h10, 32'h0, 4'hF, "err");
        wait_rsp(20, k, hc, hs, mv, e, rd);
        err_mode = 1'b0;
        total++;
        if (e !== 1'b1 || k != 3) begin
            bad++;
            $display("FAIL err_flag: err=%b rsp_cycle=%0d required 1/3", e, k);
        end
        total++;
        if (rd !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL err_rdata: rdata=%h required a5a5a5a5", rd);
        end
    endtask

    task automatic test_timeout;
        int k, hi; bit got;
        req_we = 1'b0; req_addr = 32'h10; req_sel = 4'hF;
        @(negedge clk);
        rv8 = 1'b1;
        k = 0; hi = 0; got = 0;
        while (k < 40 && !got) begin
            @(negedge clk);
            k++;
            if (k == 1) rv8 = 1'b0;
            if (cyc8) hi++;
            if (rsv8) got = 1;
        end
        total++;
        if (!got || hi != 8 || k != 9 || rse8 !== 1'b1) begin
            bad++;
            $display("FAIL timeout8: got=%0d cyc_hi=%0d rsp_cycle=%0d err=%b required 1/8/9/1", got, hi, k, rse8);
        end
        @(negedge clk);
        total++;
        if (rr8 !== 1'b1 || rsv8 !== 1'b0 || cyc8 !== 1'b0) begin
            bad++;
            $display("FAIL timeout8_idle: ready=%b rsp_valid=%b cyc=%b required 1/0/0", rr8, rsv8, cyc8);
        end
        rv0 = 1'b1;
        hi = 0; got = 0;
        for (int n = 0; n < 1001; n++) begin
            @(negedge clk);
            if (n == 0) rv0 = 1'b0;
            else begin
                if (cyc0) hi++;
                if (rsv0) got = 1;
            end
        end
        total++;
        if (hi != 1000 || got) begin
            bad++;
            $display("FAIL timeout0: cyc_hi=%0d rsp_seen=%0d required 1000/0", hi, got);
        end
    endtask

    task automatic test_reset_mid;
        int k, hc, hs; bit mv, pulse; logic e; logic [31:0] rd;
        ack_delay = 50;
        issue(1'b0, 32'h10, 32'h0, 4'hF, "mid");
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (cyc !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre: cyc=%b required 1", cyc);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (cyc !== 1'b0 || stb !== 1'b0 || rsp_valid !== 1'b0 || cyc0 !== 1'b0) begin
            bad++;
            $display("FAIL mid_async: cyc=%b stb=%b rsp_valid=%b cyc0=%b required 0/0/0/0", cyc, stb, rsp_valid, cyc0);
        end
        pulse = 0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid) pulse = 1;
        end
        rst_n = 1'b1;
        ack_delay = 1;
        @(negedge clk);
        if (rsp_valid) pulse = 1;
        total++;
        if (pulse || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_after: rsp_seen=%0d req_ready=%b required 0/1", pulse, req_ready);
        end
        issue(1'b0, 32'h10, 32'h0, 4'hF, "post");
        wait_rsp(20, k, hc, hs, mv, e, rd);
        total++;
        if (k != 3 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL mid_read: rsp_cycle=%0d err=%b rdata=%h required 3/0/deadbeef", k, e, rd);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[5]  = 32'h0BADF00D;
        mem[8]  = 32'hA5A5A5A5;
        mem[16] = 32'h12345678;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_wait_state();
        test_err_ack();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
